fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the 8-bit synchronous FIFO write port among NUM_REQ producers.
- Each producer offers data with a valid/ready handshake.
- The arbiter grants one producer per cycle and holds the grant for up to BURST consecutive beats.
- The granted beat is registered into an output stage that drives the FIFO's we/data_i and honours its full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DW, 8, data width per beat.
- BURST, 4, maximum consecutive beats granted to one requester before the grant rotates (1..16).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester beat available.
- req_data  input  NUM_REQ*DW  packed beats; requester i occupies bits [i*DW +: DW].
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero).
- fifo_we  output  1  write enable to the FIFO; registered.
- fifo_data  output  DW  write data to the FIFO; registered.
- fifo_full  input  1  full flag from the FIFO.
- grant_id  output  clog2(NUM_REQ)  index of the current owner; registered; informational.

Behaviour:
- Reset (rst_n low, asynchronous) clears all state:
  - fifo_we=0, fifo_data=0, grant_id=0, beat_cnt=0, state=IDLE.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0 while rst_n is low.
- Output stage:
  - out_accept = fifo_we && !fifo_full.
  - load_en = !fifo_we || !fifo_full.
  - When fifo_we=1 and fifo_full=1, fifo_we and fifo_data hold unchanged (no drop, no duplicate).
- req_ready is combinational:
  - req_ready[i] = load_en && (sel==i) && req_valid[i]. It is never high for a non-valid requester.
  - A transfer occurs on a clock edge where req_valid[i] && req_ready[i]. On that edge:
    - fifo_data <= req_data[i], fifo_we <= 1, grant_id <= i.
  - If load_en is high and nothing transfers, fifo_we <= 0.
- Latency: the beat is accepted at edge N and fifo_we is high in cycle N+1. Peak throughput is 1 beat/cycle.
- State machine:
  - IDLE: no owner. sel = first valid requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
    - On transfer: owner=sel, last_grant=sel, beat_cnt=1, go to OWN. If BURST==1, stay in IDLE instead.
  - OWN: sel = owner while req_valid[owner] is high and beat_cnt < BURST.
    - On transfer: beat_cnt increments. When beat_cnt reaches BURST, go to IDLE.
    - If req_valid[owner] drops, return to IDLE in the same cycle (combinational fallback). Another requester may be granted in that same cycle by the IDLE scan.
    - While load_en=0 (FIFO stalled), state, owner and beat_cnt hold.
- Fairness:
  - Rotation always starts after last_grant, so a requester that exhausts BURST cannot win again until every other valid requester has been served.
  - Worst-case wait is (NUM_REQ-1)*BURST transfers.
- Boundaries:
  - fifo_full asserted during a burst freezes the burst; the beat count is not consumed.
  - Wrap of the rotation index from NUM_REQ-1 to 0 is modulo.
  - beat_cnt is 5 bits wide and never exceeds BURST.
  - Reset mid-burst discards the registered beat and the ownership.

Optional Feature:
- Macro FIFO_ARB_PRIO_EN.
- When defined:
  - Adds input prio_req (1 bit).
  - While prio_req=1 and req_valid[0]=1, requester 0 pre-empts at the next transfer, regardless of the current owner or beat_cnt.
  - The pre-empted owner's burst ends (go to IDLE after the requester-0 beat).
  - last_grant is not updated by priority grants, so round-robin order resumes unchanged.
- When undefined:
  - No prio_req port.
  - Pure round-robin/burst behaviour as above.

Test Plan:
- Reset, then all 4 requesters valid with constant data 0x10,0x20,0x30,0x40, fifo_full=0, BURST=4 -> FIFO sees 4x0x10, 4x0x20, 4x0x30, 4x0x40, then 0x10 again. Back-to-back fifo_we. grant_id follows 0,1,2,3,0.
- Only requester 2 valid with a 6-beat stream 0xA0..0xA5 -> beats 0xA0..0xA3 are granted, the grant drops to IDLE, the rescan picks 2 again, and 0xA4..0xA5 follow. No idle cycle while valid.
- Requester 1 mid-burst after 2 beats; fifo_full=1 for 5 cycles -> fifo_we/fifo_data held at the beat-2 value, req_ready=0. After full clears, 2 more beats from requester 1, then rotation to requester 2.
- Requester 3 drops req_valid after 1 beat while requester 0 is valid -> the next cycle grants requester 0 with no bubble. last_grant=0.
- Assert rst_n=0 asynchronously mid-burst (between edges) -> fifo_we=0 immediately, req_ready=0. After release, requester 0 wins first.
- FIFO_ARB_PRIO_EN: requester 2 owns with beat_cnt=1; prio_req=1, req_valid[0]=1 with data 0xFF -> the next transfer is 0xFF from requester 0. Afterwards the rotation resumes at requester 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter feeding a registered FIFO write port.
// Define FIFO_ARB_PRIO_EN to add the prio_req pre-emption input for requester 0.
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 8,
    parameter int BURST   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DW-1:0]      req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       fifo_we,
    output logic [DW-1:0]              fifo_data,
    input  logic                       fifo_full,
`ifdef FIFO_ARB_PRIO_EN
    input  logic                       prio_req,
`endif
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int          IW      = $clog2(NUM_REQ);
    localparam logic [31:0] NREQ_U  = 32'(NUM_REQ);
    localparam logic [4:0]  BURST_C = 5'(BURST);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_OWN  = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [IW-1:0] owner_reg, owner_next;
    logic [IW-1:0] last_grant_reg, last_grant_next;
    logic [4:0]    beat_cnt_reg, beat_cnt_next;
    logic          fifo_we_reg, fifo_we_next;
    logic [DW-1:0] fifo_data_reg, fifo_data_next;
    logic [IW-1:0] grant_id_reg, grant_id_next;

    logic [DW-1:0] data_arr [NUM_REQ];
    logic [31:0]   cand;
    logic          scan_hit;
    logic [IW-1:0] scan_idx;
    logic          own_active;
    logic          prio_hit;
    logic          sel_hit;
    logic [IW-1:0] sel_idx;
    logic          load_en;
    logic          xfer;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DW +: DW];
            assign req_ready[gi] = rst_n && load_en && sel_hit &&
                                   (sel_idx == IW'(gi)) && req_valid[gi];
        end
    endgenerate

`ifdef FIFO_ARB_PRIO_EN
    assign prio_hit = prio_req && req_valid[0];
`else
    assign prio_hit = 1'b0;
`endif

    // The output register can take a new beat whenever it is empty or draining.
    assign load_en    = !fifo_we_reg || !fifo_full;
    assign xfer       = |(req_valid & req_ready);
    assign own_active = (state_reg == S_OWN) && req_valid[owner_reg] &&
                        (beat_cnt_reg < BURST_C);

    // Walk from the highest offset down so the nearest valid requester after
    // last_grant is the one left standing.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = 32'(last_grant_reg) + 32'(k);
            if (cand >= NREQ_U)
                cand = cand - NREQ_U;
            if (req_valid[cand[IW-1:0]]) begin
                scan_hit = 1'b1;
                scan_idx = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        sel_hit = scan_hit;
        sel_idx = scan_idx;
        if (prio_hit) begin
            sel_hit = 1'b1;
            sel_idx = '0;
        end else if (own_active) begin
            sel_hit = 1'b1;
            sel_idx = owner_reg;
        end
    end

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        fifo_we_next    = fifo_we_reg;
        fifo_data_next  = fifo_data_reg;
        grant_id_next   = grant_id_reg;
        if (load_en) begin
            fifo_we_next = xfer;
            if (xfer) begin
                fifo_data_next = data_arr[sel_idx];
                grant_id_next  = sel_idx;
                if (prio_hit) begin
                    // Priority beats leave last_grant alone so rotation resumes.
                    state_next    = S_IDLE;
                    beat_cnt_next = '0;
                end else if (own_active) begin
                    if (beat_cnt_reg + 5'd1 == BURST_C) begin
                        state_next    = S_IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 5'd1;
                    end
                end else begin
                    owner_next      = sel_idx;
                    last_grant_next = sel_idx;
                    if (BURST_C == 5'd1) begin
                        state_next    = S_IDLE;
                        beat_cnt_next = '0;
                    end else begin
                        state_next    = S_OWN;
                        beat_cnt_next = 5'd1;
                    end
                end
            end else if (state_reg == S_OWN && !own_active) begin
                state_next    = S_IDLE;
                beat_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            owner_reg      <= '0;
            last_grant_reg <= IW'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
            fifo_we_reg    <= 1'b0;
            fifo_data_reg  <= '0;
            grant_id_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
            fifo_we_reg    <= fifo_we_next;
            fifo_data_reg  <= fifo_data_next;
            grant_id_reg   <= grant_id_next;
        end
    end

    assign fifo_we   = fifo_we_reg;
    assign fifo_data = fifo_data_reg;
    assign grant_id  = grant_id_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DW=8, BURST=4).
// The priority step is only built when FIFO_ARB_PRIO_EN is defined.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_we;
    logic [7:0]  fifo_data;
    logic        fifo_full;
    logic [1:0]  grant_id;
`ifdef FIFO_ARB_PRIO_EN
    logic        prio_req;
`endif

    int tests_run;
    int tests_failed;

    fifo_wr_arbiter #(.NUM_REQ(4), .DW(8), .BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_we   (fifo_we),
        .fifo_data (fifo_data),
        .fifo_full (fifo_full),
`ifdef FIFO_ARB_PRIO_EN
        .prio_req  (prio_req),
`endif
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic we, input logic [7:0] d, input logic [1:0] g);
        chk({tag, ".we"},   32'(fifo_we),   32'(we));
        chk({tag, ".data"}, 32'(fifo_data), 32'(d));
        chk({tag, ".gid"},  32'(grant_id),  32'(g));
        $display("[TB] %s: we=%0d data=%02h gid=%0d", tag, fifo_we, fifo_data, grant_id);
    endtask

    // Check the combinational grant, take one edge, then check the registered beat.
    task automatic beat(input string tag, input logic [3:0] rdy, input logic [7:0] d, input logic [1:0] g);
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        tick();
        chk_out(tag, 1'b1, d, g);
    endtask

    initial begin
        logic [1:0] g;
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h40302010;
        fifo_full = 1'b0;
`ifdef FIFO_ARB_PRIO_EN
        prio_req  = 1'b0;
`endif

        // Reset state
        tick();
        tick();
        chk_out("reset", 1'b0, 8'h00, 2'd0);
        chk("reset.ready", 32'(req_ready), 32'h0);

        // All four valid: bursts of four, rotating 0,1,2,3,0
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            g = 2'((k / 4) % 4);
            beat("rr_all", 4'b0001 << g, 8'(8'h10 * (32'(g) + 1)), g);
        end

        // Only requester 2: burst of four, rescan picks 2 again without a bubble
        req_valid = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            req_data[16 +: 8] = 8'(8'hA0 + k);
            beat("single_r2", 4'b0100, 8'(8'hA0 + k), 2'd2);
        end
        req_valid = 4'b0000;
        #1;
        chk("idle.ready", 32'(req_ready), 32'h0);
        tick();
        chk("idle.we", 32'(fifo_we), 32'h0);

        // Requester 1 stalls by fifo_full after two beats, then finishes and rotates to 2
        req_valid = 4'b0110;
        req_data[8 +: 8]  = 8'hB0;
        req_data[16 +: 8] = 8'hC0;
        beat("stall_pre0", 4'b0010, 8'hB0, 2'd1);
        req_data[8 +: 8] = 8'hB1;
        beat("stall_pre1", 4'b0010, 8'hB1, 2'd1);
        fifo_full = 1'b1;
        req_data[8 +: 8] = 8'hB2;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall.ready", 32'(req_ready), 32'h0);
            tick();
            chk_out("stall.hold", 1'b1, 8'hB1, 2'd1);
        end
        fifo_full = 1'b0;
        beat("stall_post0", 4'b0010, 8'hB2, 2'd1);
        req_data[8 +: 8] = 8'hB3;
        beat("stall_post1", 4'b0010, 8'hB3, 2'd1);
        beat("stall_rot", 4'b0100, 8'hC0, 2'd2);

        // Requester 3 drops after one beat; requester 0 takes over with no bubble
        req_valid = 4'b1000;
        req_data[24 +: 8] = 8'hD3;
        beat("drop_r3", 4'b1000, 8'hD3, 2'd3);
        req_valid = 4'b0001;
        req_data[7:0] = 8'h05;
        beat("drop_r0", 4'b0001, 8'h05, 2'd0);
        // With 0 and 3 valid, 0 finishes its burst; last_grant=0 makes 3 next
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++)
            beat("drop_r0_burst", 4'b0001, 8'h05, 2'd0);
        beat("drop_next_r3", 4'b1000, 8'hD3, 2'd3);

        // Asynchronous reset between edges in the middle of requester 3's burst
        beat("arst_pre", 4'b1000, 8'hD3, 2'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 8'h00, 2'd0);
        chk("arst.ready", 32'(req_ready), 32'h0);
        #2;
        rst_n = 1'b1;
        beat("arst_post", 4'b0001, 8'h05, 2'd0);

`ifdef FIFO_ARB_PRIO_EN
        // Requester 2 owns; requester 0 pre-empts, rotation resumes at 3
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'h22;
        beat("prio_own_r2", 4'b0100, 8'h22, 2'd2);
        prio_req  = 1'b1;
        req_valid = 4'b0101;
        req_data[7:0] = 8'hFF;
        beat("prio_r0", 4'b0001, 8'hFF, 2'd0);
        prio_req  = 1'b0;
        req_valid = 4'b1101;
        beat("prio_resume", 4'b1000, 8'hD3, 2'd3);
`endif

        req_valid = 4'b0000;
        tick();
        tick();
        chk("end.we", 32'(fifo_we), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
